// File: rtl/ssc_corr_collector_pkg.sv
// Shared register map, event word layout and status word layout for the
// correlator event collector.
package ssc_corr_collector_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CH_ID_W = 4;
    localparam int unsigned TS_W    = 27;

    localparam logic [15:0] SSC_ADDR_SEEN  = 16'h0108;
    localparam logic [15:0] SSC_ADDR_EVT   = 16'h010C;
    localparam logic [15:0] SSC_ADDR_STAT  = 16'h0110;
    localparam logic [15:0] SSC_ADDR_IRQEN = 16'h0114;

    // Queued event: valid flag, channel id, truncated sample timestamp
    typedef struct packed {
        logic               valid;
        logic [CH_ID_W-1:0] ch;
        logic [TS_W-1:0]    ts;
    } evt_word_t;

    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] drop_cnt;
        logic [4:0] rsvd_mid;
        logic       overflow;
        logic       full;
        logic       empty;
        logic [2:0] rsvd_lo;
        logic [4:0] level;
    } stat_word_t;

endpackage

// File: rtl/ssc_evt_fifo.sv
// Synchronous show-ahead event FIFO; flush overrides push and pop.
module ssc_evt_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign level   = count;
    assign head    = mem[rd_ptr];
    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/ssc_corr_collector.sv
// Collects correlation strobes from the slices into a sticky seen vector and a
// timestamped event FIFO, merges slice read data and drives the interrupt.
module ssc_corr_collector
    import ssc_corr_collector_pkg::*;
#(
    parameter int unsigned NCH        = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     addr,
    input  logic [DATA_W-1:0]     Wdata,
    input  logic                  write,
    input  logic                  read,
    input  logic [NCH-1:0]        cseen,
    input  logic [DATA_W-1:0]     sample_cnt,
    input  logic [NCH*DATA_W-1:0] Rdata_ch,
    output logic [DATA_W-1:0]     Rdata,
    output logic                  irq
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [NCH-1:0]    prev_cseen;
    logic [NCH-1:0]    seen;
    logic [NCH-1:0]    pending;
    logic [NCH-1:0]    irq_en_ch;
    logic              irq_en_fifo;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic              prev_seen_rd;
    logic              prev_evt_rd;

    logic [NCH-1:0]    rise;
    logic [NCH-1:0]    svc_clear;
    logic              svc_valid;
    logic [CH_ID_W-1:0] svc_ch;
    logic              hit_seen, hit_evt, hit_stat, hit_irqen;
    logic              seen_clr, pop_req, pop_eff, flush, drop;
    logic              fifo_full, fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [DATA_W-1:0] fifo_head;
    evt_word_t         evt;
    stat_word_t        stat;
    logic [DATA_W-1:0] local_rd;
    logic [DATA_W-1:0] slice_or;
    logic              unused_bits;

    assign hit_seen  = (addr[15:0] == SSC_ADDR_SEEN);
    assign hit_evt   = (addr[15:0] == SSC_ADDR_EVT);
    assign hit_stat  = (addr[15:0] == SSC_ADDR_STAT);
    assign hit_irqen = (addr[15:0] == SSC_ADDR_IRQEN);

    // Side effects fire only on the first cycle of a held read
    assign seen_clr  = read & hit_seen & ~prev_seen_rd;
    assign pop_req   = read & hit_evt & ~prev_evt_rd;
    assign pop_eff   = pop_req & ~fifo_empty;
    assign flush     = write & hit_stat & Wdata[0];

    assign rise      = cseen & ~prev_cseen;
    assign svc_valid = |pending;
    assign svc_clear = pending & (~pending + NCH'(1));
    assign drop      = svc_valid & (flush | (fifo_full & ~pop_eff));

    always_comb begin
        svc_ch = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (pending[i]) svc_ch = CH_ID_W'(i);
        end
    end

    always_comb begin
        evt       = '0;
        evt.valid = 1'b1;
        evt.ch    = svc_ch;
        evt.ts    = sample_cnt[TS_W-1:0];
    end

    ssc_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (svc_valid),
        .pop   (pop_req),
        .flush (flush),
        .data  (evt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cseen   <= '0;
            seen         <= '0;
            pending      <= '0;
            irq_en_ch    <= '0;
            irq_en_fifo  <= 1'b0;
            overflow     <= 1'b0;
            drop_cnt     <= '0;
            prev_seen_rd <= 1'b0;
            prev_evt_rd  <= 1'b0;
            irq          <= 1'b0;
        end else begin
            prev_cseen   <= cseen;
            seen         <= (seen & ~{NCH{seen_clr}}) | rise;
            pending      <= (pending & ~svc_clear) | rise;
            prev_seen_rd <= read & hit_seen;
            prev_evt_rd  <= read & hit_evt;
            if (write && hit_irqen) begin
                irq_en_ch   <= Wdata[NCH-1:0];
                irq_en_fifo <= Wdata[31];
            end
            // A flush restarts drop accounting, but an event lost to it still counts
            if (flush) begin
                overflow <= drop;
                drop_cnt <= 8'(drop);
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            irq <= (|(seen & irq_en_ch)) | (irq_en_fifo & ~fifo_empty);
        end
    end

    always_comb begin
        stat          = '0;
        stat.drop_cnt = drop_cnt;
        stat.overflow = overflow;
        stat.full     = fifo_full;
        stat.empty    = fifo_empty;
        stat.level    = 5'(fifo_level);
    end

    always_comb begin
        slice_or = '0;
        for (int n = 0; n < int'(NCH); n++) begin
            slice_or = slice_or | Rdata_ch[n*DATA_W +: DATA_W];
        end
        local_rd = '0;
        if (hit_seen)  local_rd = DATA_W'(seen);
        if (hit_evt)   local_rd = fifo_empty ? '0 : fifo_head;
        if (hit_stat)  local_rd = stat;
        if (hit_irqen) begin
            local_rd     = DATA_W'(irq_en_ch);
            local_rd[31] = irq_en_fifo;
        end
        Rdata = read ? (slice_or | local_rd) : '0;
    end

    assign unused_bits = ^{addr[31:16], Wdata, sample_cnt[DATA_W-1:TS_W]};

endmodule
